// File: rtl/mux_scan_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_scan_sequencer_pkg                                           |
// | Shared types and sizes for the 4:1 mux scan sequencer.           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mux_scan_sequencer_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mux_scan_sequencer_settle_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_scan_sequencer_settle_timer                                  |
// | Loadable down-counter; zero flags the last settle cycle.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mux_scan_sequencer_settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Saturates at zero so a stray enable never wraps to a long settle.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_scan_sequencer                                               |
// | Walks the 4:1 mux select, samples each channel after a settle    |
// | time and reports a frame snapshot plus change mask.              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cont_mode,
  input  logic              mux_in,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              frame_valid,
  output logic [NUM_CH-1:0] frame,
  output logic [NUM_CH-1:0] changed
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_CH     = SEL_W'(NUM_CH - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              frame_valid_q, frame_valid_d;
  logic [NUM_CH-1:0] frame_q, frame_d;
  logic [NUM_CH-1:0] changed_q, changed_d;
  logic [NUM_CH-1:0] capture_q, capture_d;
  logic              tmr_load;
  logic              tmr_en;
  logic              tmr_zero;

  mux_scan_sequencer_settle_timer #(
    .CNT_W (CNT_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (SETTLE_LOAD),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    capture_d = capture_q;
    frame_d   = frame_q;
    changed_d = changed_q;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;

    case (state_q)
      IDLE: begin
        sel_d = '0;
        if (start) begin
          state_d  = SETTLE;
          tmr_load = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          state_d = SAMPLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      SAMPLE: begin
        capture_d[sel_q] = mux_in;
        if (sel_q == LAST_CH) begin
          // Last channel bypasses the capture register to land in this frame.
          state_d                 = DONE;
          frame_d                 = capture_q;
          frame_d[NUM_CH-1]       = mux_in;
          changed_d               = frame_d ^ frame_q;
        end else begin
          state_d  = SETTLE;
          sel_d    = sel_q + SEL_W'(1);
          tmr_load = 1'b1;
        end
      end
      DONE: begin
        sel_d = '0;
        if (cont_mode) begin
          state_d  = SETTLE;
          tmr_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase

    // Cancel discards the partial scan but leaves the last reported frame intact.
    if (abort) begin
      state_d   = IDLE;
      sel_d     = '0;
      capture_d = '0;
      frame_d   = frame_q;
      changed_d = changed_q;
      tmr_load  = 1'b0;
      tmr_en    = 1'b0;
    end

    busy_d        = (state_d != IDLE);
    frame_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_q       <= '0;
      changed_q     <= '0;
      capture_q     <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      busy_q        <= busy_d;
      frame_valid_q <= frame_valid_d;
      frame_q       <= frame_d;
      changed_q     <= changed_d;
      capture_q     <= capture_d;
    end
  end

  assign sel         = sel_q;
  assign busy        = busy_q;
  assign frame_valid = frame_valid_q;
  assign frame       = frame_q;
  assign changed     = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mux_scan_sequencer                                            |
// | Scoreboard bench: a 4:1 mux model feeds the sequencer.           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_mux_scan_sequencer;

  localparam int SETTLE_CYCLES = 2;
  localparam int SCAN_LAT      = 4 * (SETTLE_CYCLES + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       cont_mode;
  logic [3:0] mux_data;
  logic       mux_in;
  logic [1:0] sel;
  logic       busy;
  logic       frame_valid;
  logic [3:0] frame;
  logic [3:0] changed;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [3:0] model_prev;
  logic [3:0] model_changed;

  assign mux_in = mux_data[sel];

  always #5 clk = ~clk;

  mux_scan_sequencer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cont_mode   (cont_mode),
    .mux_in      (mux_in),
    .sel         (sel),
    .busy        (busy),
    .frame_valid (frame_valid),
    .frame       (frame),
    .changed     (changed)
  );

  task automatic push_expected();
    model_changed = mux_data ^ model_prev;
    exp_q.push_back({mux_data, model_changed});
    model_prev = mux_data;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_fv(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (frame_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; cont_mode = 1'b0;
    mux_data = 4'b0000; model_prev = 4'b0000; model_changed = 4'b0000;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({sel, busy, frame_valid, frame, changed} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_state: got sel=%0d busy=%b fv=%b frame=%b changed=%b, want all zero",
               sel, busy, frame_valid, frame, changed);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_scan();
    logic [7:0] exp;
    int lat;
    int bad_sel;
    int bad_fv;
    mux_data = 4'b1101;
    push_expected();
    do_start();
    n_cmp++;
    if (busy !== 1'b1 || sel !== 2'd0) begin
      n_err++;
      $display("FAIL first_busy: got busy=%b sel=%0d, want busy=1 sel=0", busy, sel);
    end
    lat = -1; bad_sel = 0; bad_fv = 0;
    for (int i = 1; i <= SCAN_LAT + 1; i++) begin
      @(negedge clk);
      if (i < SCAN_LAT && sel !== 2'(i / (SETTLE_CYCLES + 1))) bad_sel++;
      if (frame_valid !== (i == SCAN_LAT)) bad_fv++;
      if (frame_valid === 1'b1 && lat < 0) begin
        lat = i;
        exp = exp_q.pop_front();
        n_cmp++;
        if (frame !== exp[7:4] || changed !== exp[3:0]) begin
          n_err++;
          $display("FAIL scan1_frame: got frame=%b changed=%b, want frame=%b changed=%b",
                   frame, changed, exp[7:4], exp[3:0]);
        end
      end
      if (i == SCAN_LAT + 1) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL scan1_busy_drop: got busy=%b, want 0", busy);
        end
      end
    end
    n_cmp++;
    if (bad_sel != 0) begin
      n_err++;
      $display("FAIL sel_walk: got %0d wrong sel cycles, want 0", bad_sel);
    end
    n_cmp++;
    if (bad_fv != 0 || lat != SCAN_LAT) begin
      n_err++;
      $display("FAIL scan1_latency: got lat=%0d bad_fv=%0d, want lat=%0d bad_fv=0", lat, bad_fv, SCAN_LAT);
    end
  endtask

  task automatic test_repeat_scans();
    logic [7:0] exp;
    int lat;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) mux_data = 4'b1111;
      push_expected();
      do_start();
      wait_fv(SCAN_LAT + 4, lat);
      exp = exp_q.pop_front();
      n_cmp++;
      if (lat != SCAN_LAT || frame !== exp[7:4] || changed !== exp[3:0]) begin
        n_err++;
        $display("FAIL repeat_scan%0d: got lat=%0d frame=%b changed=%b, want lat=%0d frame=%b changed=%b",
                 k, lat, frame, changed, SCAN_LAT, exp[7:4], exp[3:0]);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_continuous();
    logic [7:0] exp;
    logic [3:0] pats [4];
    int lat;
    int gap;
    int bad_busy;
    pats[0] = 4'b0011; pats[1] = 4'b1010; pats[2] = 4'b1010; pats[3] = 4'b0101;
    cont_mode = 1'b1;
    mux_data = pats[0];
    push_expected();
    do_start();
    wait_fv(SCAN_LAT + 4, lat);
    exp = exp_q.pop_front();
    n_cmp++;
    if (lat != SCAN_LAT || frame !== exp[7:4] || changed !== exp[3:0]) begin
      n_err++;
      $display("FAIL cont_first: got lat=%0d frame=%b changed=%b, want lat=%0d frame=%b changed=%b",
               lat, frame, changed, SCAN_LAT, exp[7:4], exp[3:0]);
    end
    for (int k = 1; k < 4; k++) begin
      mux_data = pats[k];
      push_expected();
      gap = 0; bad_busy = 0;
      while (gap < SCAN_LAT + 6) begin
        @(negedge clk);
        gap++;
        if (busy !== 1'b1) bad_busy++;
        if (k == 3 && gap == 5) cont_mode = 1'b0;
        if (frame_valid === 1'b1) break;
      end
      exp = exp_q.pop_front();
      n_cmp++;
      if (gap != SCAN_LAT + 1 || bad_busy != 0 || frame !== exp[7:4] || changed !== exp[3:0]) begin
        n_err++;
        $display("FAIL cont_frame%0d: got gap=%0d bad_busy=%0d frame=%b changed=%b, want gap=%0d bad_busy=0 frame=%b changed=%b",
                 k, gap, bad_busy, frame, changed, SCAN_LAT + 1, exp[7:4], exp[3:0]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || sel !== 2'd0) begin
      n_err++;
      $display("FAIL cont_stop: got busy=%b sel=%0d, want busy=0 sel=0", busy, sel);
    end
    wait_fv(SCAN_LAT + 4, lat);
    n_cmp++;
    if (lat != -1) begin
      n_err++;
      $display("FAIL cont_no_extra: got frame_valid after %0d cycles, want none", lat);
    end
  endtask

  task automatic test_abort();
    int lat;
    mux_data = 4'b0110;
    do_start();
    repeat (2 * (SETTLE_CYCLES + 1)) @(negedge clk);
    n_cmp++;
    if (sel !== 2'd2 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort_setup: got sel=%0d busy=%b, want sel=2 busy=1", sel, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || sel !== 2'd0 || frame_valid !== 1'b0 ||
        frame !== model_prev || changed !== model_changed) begin
      n_err++;
      $display("FAIL abort_state: got busy=%b sel=%0d fv=%b frame=%b changed=%b, want 0 0 0 %b %b",
               busy, sel, frame_valid, frame, changed, model_prev, model_changed);
    end
    wait_fv(SCAN_LAT + 8, lat);
    n_cmp++;
    if (lat != -1) begin
      n_err++;
      $display("FAIL abort_no_frame: got frame_valid after %0d cycles, want none", lat);
    end
  endtask

  task automatic test_start_while_busy();
    logic [7:0] exp;
    int lat;
    int extra;
    push_expected();
    do_start();
    lat = -1;
    for (int i = 1; i <= SCAN_LAT + 2; i++) begin
      start = (i == 4 || i == 9);
      @(negedge clk);
      if (frame_valid === 1'b1 && lat < 0) lat = i;
    end
    start = 1'b0;
    exp = exp_q.pop_front();
    n_cmp++;
    if (lat != SCAN_LAT || frame !== exp[7:4] || changed !== exp[3:0]) begin
      n_err++;
      $display("FAIL busy_start_frame: got lat=%0d frame=%b changed=%b, want lat=%0d frame=%b changed=%b",
               lat, frame, changed, SCAN_LAT, exp[7:4], exp[3:0]);
    end
    wait_fv(2 * SCAN_LAT, extra);
    n_cmp++;
    if (extra != -1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_start_ignored: got extra frame at %0d busy=%b, want none busy=0", extra, busy);
    end
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || sel !== 2'd0) begin
      n_err++;
      $display("FAIL abort_start_idle: got busy=%b sel=%0d, want busy=0 sel=0", busy, sel);
    end
    wait_fv(SCAN_LAT + 4, extra);
    n_cmp++;
    if (extra != -1) begin
      n_err++;
      $display("FAIL abort_start_no_frame: got frame_valid after %0d cycles, want none", extra);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp;
    int lat;
    mux_data = 4'b1001;
    do_start();
    repeat (SETTLE_CYCLES) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({sel, busy, frame_valid, frame, changed} !== 12'h000) begin
      n_err++;
      $display("FAIL async_reset: got sel=%0d busy=%b fv=%b frame=%b changed=%b, want all zero",
               sel, busy, frame_valid, frame, changed);
    end
    @(negedge clk);
    rst = 1'b0;
    model_prev = 4'b0000;
    model_changed = 4'b0000;
    @(negedge clk);
    mux_data = 4'b1010;
    push_expected();
    do_start();
    wait_fv(SCAN_LAT + 4, lat);
    exp = exp_q.pop_front();
    n_cmp++;
    if (lat != SCAN_LAT || frame !== exp[7:4] || changed !== exp[3:0] || changed !== frame) begin
      n_err++;
      $display("FAIL post_reset_scan: got lat=%0d frame=%b changed=%b, want lat=%0d frame=%b changed=%b",
               lat, frame, changed, SCAN_LAT, exp[7:4], exp[3:0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_repeat_scans();
    test_continuous();
    test_abort();
    test_start_while_busy();
    test_async_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending frames, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
